// File: rtl/mem_stage.sv
// Memory-access stage: data-memory req/ack handshake with timeout, byte-lane steering, load alignment/extension, MEM/WB register.
// Optional MISALIGN_TRAP_EN: misaligned H/W accesses skip the bus and retire with o_trap=1.
module mem_stage #(
   parameter int         XLEN    = 32,
   parameter logic [3:0] ACK_TMO = 4'd15
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_vld,
   input  logic [XLEN-1:0] i_res,
   input  logic            i_mem_rd,
   input  logic            i_mem_wr,
   input  logic [2:0]      i_funct3,
   input  logic            i_flush,
   input  logic [4:0]      i_rd_waddr,
   input  logic            i_rd_wen,
   input  logic [XLEN-1:0] i_inst,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_nxt_pc,
   input  logic [4:0]      i_rs1_raddr,
   input  logic [4:0]      i_rs2_raddr,
   input  logic [XLEN-1:0] i_rs1_rdata,
   input  logic [XLEN-1:0] i_rs2_rdata,
   output logic            o_dmem_req,
   output logic [XLEN-1:0] o_dmem_addr,
   output logic            o_dmem_wen,
   output logic [3:0]      o_dmem_mask,
   output logic [XLEN-1:0] o_dmem_wdata,
   input  logic            i_dmem_ack,
   input  logic [XLEN-1:0] i_dmem_rdata,
   output logic            o_stall,
   output logic            o_mem_reg,
   output logic [XLEN-1:0] o_dmem_rdata,
   output logic [XLEN-1:0] o_res,
   output logic            o_vld,
   output logic [4:0]      o_rd_waddr,
   output logic            o_rd_wen,
   output logic [XLEN-1:0] o_inst,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_nxt_pc,
   output logic [4:0]      o_rs1_raddr,
   output logic [4:0]      o_rs2_raddr,
   output logic [XLEN-1:0] o_rs1_rdata,
   output logic [XLEN-1:0] o_rs2_rdata
`ifdef MISALIGN_TRAP_EN
   ,
   output logic            o_trap
`endif
);

   // state  | meaning
   // IDLE   | no access outstanding; request follows memop combinationally
   // WAIT   | request held, waiting for ack or timeout
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   logic [0:0]      state;
   logic [3:0]      tmo_cnt;
   logic [1:0]      a_lo;
   logic            misalign;
   logic            memop;
   logic            in_wait;
   logic            abandon;
   logic            req_int;
   logic            stall_int;
   logic            wb_vld;
   logic [1:0]      rd_sh;
   logic [3:0]      mask_int;
   logic [XLEN-1:0] wdata_int;
   logic [XLEN-1:0] rd_shifted;
   logic [XLEN-1:0] ld_data;

   assign a_lo = i_res[1:0];

`ifdef MISALIGN_TRAP_EN
   assign misalign = i_vld & (i_mem_rd | i_mem_wr) &
                     (((i_funct3[1:0] == 2'b01) & a_lo[0]) |
                      ((i_funct3[1:0] == 2'b10) & (a_lo != 2'b00)));
`else
   assign misalign = 1'b0;
`endif

   assign memop   = i_vld & (i_mem_rd | i_mem_wr) & ~misalign;
   assign in_wait = (state == S_WAIT);
   // tmo_cnt equals the number of the current WAIT cycle, so the last one is ACK_TMO
   assign abandon   = in_wait & ~i_dmem_ack & (tmo_cnt == ACK_TMO);
   assign req_int   = in_wait | memop;
   assign stall_int = in_wait ? (~i_dmem_ack & ~abandon) : (memop & ~i_dmem_ack);
   assign wb_vld    = i_vld & ~i_flush & ~abandon & ~stall_int;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state   <= S_IDLE;
         tmo_cnt <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (memop && !i_dmem_ack) begin
                  state   <= S_WAIT;
                  tmo_cnt <= 4'd1;
               end
            end
            default: begin
               if (i_dmem_ack || abandon) begin
                  state   <= S_IDLE;
                  tmo_cnt <= 4'd0;
               end else begin
                  tmo_cnt <= tmo_cnt + 4'd1;
               end
            end
         endcase
      end
   end

   always_comb begin
      mask_int  = 4'b1111;
      wdata_int = i_rs2_rdata;
      rd_sh     = 2'b00;
      case (i_funct3[1:0])
         2'b00: begin
            rd_sh     = a_lo;
            wdata_int = {4{i_rs2_rdata[7:0]}};
            if (i_mem_wr) mask_int = 4'b0001 << a_lo;
         end
         2'b01: begin
            rd_sh     = {a_lo[1], 1'b0};
            wdata_int = {2{i_rs2_rdata[15:0]}};
            if (i_mem_wr) mask_int = 4'b0011 << {a_lo[1], 1'b0};
         end
         default: ;
      endcase
      rd_shifted = i_dmem_rdata >> {rd_sh, 3'b000};
      case (i_funct3)
         3'b000:  ld_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
         3'b001:  ld_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
         3'b100:  ld_data = {24'd0, rd_shifted[7:0]};
         3'b101:  ld_data = {16'd0, rd_shifted[15:0]};
         default: ld_data = i_dmem_rdata;
      endcase
   end

   assign o_dmem_req   = i_rst_n & req_int;
   assign o_stall      = i_rst_n & stall_int;
   assign o_dmem_wen   = i_rst_n & i_mem_wr;
   assign o_dmem_addr  = {XLEN{i_rst_n}} & {i_res[XLEN-1:2], 2'b00};
   assign o_dmem_mask  = {4{i_rst_n}} & mask_int;
   assign o_dmem_wdata = {XLEN{i_rst_n}} & wdata_int;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_mem_reg    <= 1'b0;
         o_dmem_rdata <= '0;
         o_res        <= '0;
         o_vld        <= 1'b0;
         o_rd_waddr   <= '0;
         o_rd_wen     <= 1'b0;
         o_inst       <= '0;
         o_pc         <= '0;
         o_nxt_pc     <= '0;
         o_rs1_raddr  <= '0;
         o_rs2_raddr  <= '0;
         o_rs1_rdata  <= '0;
         o_rs2_rdata  <= '0;
`ifdef MISALIGN_TRAP_EN
         o_trap       <= 1'b0;
`endif
      end else begin
         o_mem_reg    <= i_mem_rd;
         o_dmem_rdata <= ld_data;
         o_res        <= i_res;
         o_vld        <= wb_vld;
         o_rd_waddr   <= i_rd_waddr;
         o_rd_wen     <= wb_vld & i_rd_wen & ~misalign;
         o_inst       <= i_inst;
         o_pc         <= i_pc;
         o_nxt_pc     <= i_nxt_pc;
         o_rs1_raddr  <= i_rs1_raddr;
         o_rs2_raddr  <= i_rs2_raddr;
         o_rs1_rdata  <= i_rs1_rdata;
         o_rs2_rdata  <= i_rs2_rdata;
`ifdef MISALIGN_TRAP_EN
         o_trap       <= wb_vld & misalign;
`endif
      end
   end

endmodule
